uart_tx_param: RTL and testbench

Parametrised UART transmitter with an input FIFO, configurable data width, parity and stop bits. It accepts bytes from on-chip logic through a valid/ready handshake and serialises them LSB-first onto a single TX line. Frames go back-to-back while the FIFO holds data. It is the general-purpose successor of the fixed 8N1, 9600-baud, single-byte transmitter used by the button/UART designs.

---
 rtl/uart_tx_param.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter with an input FIFO. Words are accepted through
// a valid/ready handshake, queued, and serialised LSB first as
//   start(0) | DATA_BITS payload | optional parity | STOP_BITS stop(1)
// Frames follow each other with no idle gap while the FIFO holds data.
//
// Parameters
//   CLK_HZ, BAUD : bit period DIV = CLK_HZ / BAUD clocks (DIV >= 2)
//   DATA_BITS    : payload width, 5..8
//   PARITY       : 0 none, 1 odd, 2 even
//   STOP_BITS    : 1 or 2
//   DEPTH        : FIFO entries, power of two, >= 2
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset (aborts frame, empties FIFO)
//   in_data   in   word to send
//   in_valid  in   in_data valid
//   in_ready  out  FIFO not full; transfer on in_valid & in_ready
//   tx        out  registered serial line, idle high
//   busy      out  frame in progress or FIFO non-empty
//   level     out  FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int CLK_HZ    = 48_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Odd parity inverts the plain XOR so payload ^ parity == 1.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ ((PARITY == 1) ? 1'b1 : 1'b0);
    endfunction

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;

    state_t               w_next_state;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;
    logic                 w_cnt_last;
    logic                 w_bit_last;

    assign w_nonempty = (r_level != LVL_ZERO);
    assign in_ready   = (r_level != LVL_FULL);
    assign w_push     = in_valid & in_ready;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    // r_bit counts payload bits in DATA and stop bits in STOP.
    assign w_bit_last = (r_state == S_DATA) ? (r_bit == DATA_LAST) : (r_bit == STOP_LAST);

    assign tx    = r_tx;
    assign level = r_level;
    assign busy  = (r_state != S_IDLE) | w_nonempty;

    // Next-state decode; the head word is popped on every transition into START.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_next_state = S_START;
                    w_pop        = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_next_state = S_DATA;
                end else begin
                    w_next_state = S_START;
                end
            end
            S_DATA: begin
                if (w_cnt_last && w_bit_last) begin
                    w_next_state = (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_PARITY: begin
                if (w_cnt_last) begin
                    w_next_state = S_STOP;
                end else begin
                    w_next_state = S_PARITY;
                end
            end
            S_STOP: begin
                if (w_cnt_last && w_bit_last) begin
                    if (w_nonempty) begin
                        w_next_state = S_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_STOP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_pop        = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= LVL_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // State register, baud counter and bit index; both counters restart on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= {DATA_BITS{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end
            if (w_next_state != r_state) begin
                r_cnt <= {CNT_W{1'b0}};
                r_bit <= 3'd0;
            end else if (r_state != S_IDLE) begin
                if (w_cnt_last) begin
                    r_cnt <= {CNT_W{1'b0}};
                    r_bit <= r_bit + 3'd1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Line driver: registered from the current state so tx lags state by one clock and never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE:   r_tx <= 1'b1;
                S_START:  r_tx <= 1'b0;
                S_DATA:   r_tx <= r_shift[r_bit];
                S_PARITY: r_tx <= parity_bit(r_shift);
                S_STOP:   r_tx <= 1'b1;
                default:  r_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three instances (8N1, 7E2, 8O1, DIV=16)
// checked every clock against a frame-level line model, plus table-driven
// frames and hand-written multi-cycle sequences.
module tb_uart_tx_param;

    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int DIV    = 16;
    localparam int DEPTH  = 4;
    localparam int ND     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld    [ND];
    logic [7:0] din    [ND];
    logic       tx_s   [ND];
    logic       busy_s [ND];
    logic       rdy_s  [ND];
    logic [2:0] lvl_s  [ND];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    bit         line_q [ND][$];
    logic [7:0] fq     [ND][$];
    logic [7:0] src_q  [ND][$];
    bit         pop_pend [ND];
    bit         acc_pend [ND];
    logic [7:0] acc_word [ND];
    bit         rst_prev = 1'b1;
    int         last_acc [ND];
    bit         gap_en = 1'b0;

    typedef struct {
        int         dut;
        logic [7:0] word;
        int         nbits;
        logic [11:0] bits;
    } vec_t;
    vec_t tbl [7];

    uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy_s[0]), .tx(tx_s[0]), .busy(busy_s[0]), .level(lvl_s[0]));

    uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(din[1][6:0]), .in_valid(vld[1]),
        .in_ready(rdy_s[1]), .tx(tx_s[1]), .busy(busy_s[1]), .level(lvl_s[1]));

    uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vld[2]),
        .in_ready(rdy_s[2]), .tx(tx_s[2]), .busy(busy_s[2]), .level(lvl_s[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int db_of(input int d);
        return (d == 1) ? 7 : 8;
    endfunction
    function automatic int par_of(input int d);
        return (d == 1) ? 2 : ((d == 2) ? 1 : 0);
    endfunction
    function automatic int sb_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Append one complete frame for word w to the expected line of instance d.
    function automatic void add_frame(input int d, input logic [7:0] w);
        bit fb[$];
        int ones;
        ones = 0;
        fb.push_back(1'b0);
        for (int i = 0; i < db_of(d); i++) begin
            fb.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (par_of(d) == 1) fb.push_back((ones % 2) == 0);
        else if (par_of(d) == 2) fb.push_back((ones % 2) == 1);
        for (int s = 0; s < sb_of(d); s++) fb.push_back(1'b1);
        foreach (fb[i]) begin
            repeat (DIV) line_q[d].push_back(fb[i]);
        end
    endfunction

    // Reference model, evaluated once per clock between active edges.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            bit expv;
            if (rst_prev) begin
                fq[d].delete();
                line_q[d].delete();
                pop_pend[d] = 1'b0;
            end else begin
                if (pop_pend[d]) void'(fq[d].pop_front());
                if (acc_pend[d]) fq[d].push_back(acc_word[d]);
                pop_pend[d] = 1'b0;
            end
            if (line_q[d].size() != 0) expv = line_q[d].pop_front();
            else expv = 1'b1;
            chk($sformatf("d%0d_tx", d), int'(tx_s[d]), int'(expv));
            chk($sformatf("d%0d_level", d), int'(lvl_s[d]), fq[d].size());
            chk($sformatf("d%0d_ready", d), int'(rdy_s[d]), int'(fq[d].size() != DEPTH));
            chk($sformatf("d%0d_busy", d), int'(busy_s[d]),
                int'(line_q[d].size() != 0 || fq[d].size() != 0));
            // next frame starts after the last stop sample, or one clock after idle accept
            if (fq[d].size() != 0 && line_q[d].size() <= 1) begin
                if (line_q[d].size() == 0) line_q[d].push_back(1'b1);
                add_frame(d, fq[d][0]);
                pop_pend[d] = 1'b1;
            end
            acc_pend[d] = vld[d] && (fq[d].size() != DEPTH) && !rst;
            acc_word[d] = din[d] & 8'((1 << db_of(d)) - 1);
        end
        rst_prev = rst;
    end

    task automatic drive_step();
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            if (vld[d] && acc_pend[d]) begin
                last_acc[d] = cyc;
                void'(src_q[d].pop_front());
                vld[d] = 1'b0;
            end
            if (!vld[d] && src_q[d].size() != 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                vld[d] = 1'b1;
                din[d] = src_q[d][0];
            end
        end
    endtask

    task automatic to_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    function automatic bit all_idle();
        for (int d = 0; d < ND; d++) begin
            if (line_q[d].size() != 0 || fq[d].size() != 0 || src_q[d].size() != 0 ||
                vld[d] || pop_pend[d]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_idle(input string name);
        int n;
        n = 0;
        while (!all_idle() && n < 8000) begin
            drive_step();
            n++;
        end
        chk({name, "_drain"}, int'(n < 8000), 1);
    endtask

    initial begin
        int d, n0, lim, rr, lows;
        bit saw_full;
        logic [11:0] fb;
        logic [7:0] w;

        for (int i = 0; i < ND; i++) begin
            vld[i] = 1'b0;
            din[i] = 8'h00;
        end
        tbl[0] = '{0, 8'hA5, 10, 12'h34A};
        tbl[1] = '{1, 8'h55, 11, 12'h6AA};
        tbl[2] = '{2, 8'h00, 11, 12'h600};
        tbl[3] = '{2, 8'h01, 11, 12'h402};
        tbl[4] = '{0, 8'hFF, 10, 12'h3FE};
        tbl[5] = '{0, 8'h00, 10, 12'h200};
        tbl[6] = '{1, 8'h01, 11, 12'h702};

        // reset values
        to_neg(2);
        chk("rst_tx", int'(tx_s[0]), 1);
        chk("rst_busy", int'(busy_s[0]), 0);
        chk("rst_ready", int'(rdy_s[0]), 1);
        chk("rst_level", int'(lvl_s[0]), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // table-driven single frames from idle
        for (int t = 0; t < 7; t++) begin
            d  = tbl[t].dut;
            fb = tbl[t].bits;
            src_q[d].push_back(tbl[t].word);
            lim = 0;
            while (src_q[d].size() != 0 && lim < 20) begin
                drive_step();
                lim++;
            end
            chk("tbl_accept", int'(lim < 20), 1);
            n0 = last_acc[d];
            to_neg(n0);
            chk("tbl_level_after_push", int'(lvl_s[d]), 1);
            to_neg(n0 + 1);
            chk("tbl_tx_before_start", int'(tx_s[d]), 1);
            for (int b = 0; b < tbl[t].nbits; b++) begin
                to_neg(n0 + 2 + b * DIV);
                chk($sformatf("tbl%0d_bit%0d_first", t, b), int'(tx_s[d]), int'(fb[b]));
                if (b == tbl[t].nbits - 1) begin
                    to_neg(n0 + tbl[t].nbits * DIV);
                    chk("tbl_busy_last", int'(busy_s[d]), 1);
                end
                to_neg(n0 + 1 + (b + 1) * DIV);
                chk($sformatf("tbl%0d_bit%0d_last", t, b), int'(tx_s[d]), int'(fb[b]));
            end
            chk("tbl_busy_end", int'(busy_s[d]), 0);
            chk("tbl_level_end", int'(lvl_s[d]), 0);
        end

        // six words with valid held: FIFO fills, frames back to back
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) src_q[0].push_back(8'(8'h30 + i));
        lim = 0;
        while (src_q[0].size() != 0 && lim < 3000) begin
            drive_step();
            if (lvl_s[0] == 3'd4 && rdy_s[0] == 1'b0) saw_full = 1'b1;
            lim++;
        end
        chk("six_full_seen", int'(saw_full), 1);
        run_idle("six");
        chk("six_level_end", int'(lvl_s[0]), 0);

        // reset in the middle of the data bits with three words queued
        for (int i = 0; i < 4; i++) src_q[0].push_back(8'(8'hC1 + i));
        drive_step();
        drive_step();
        n0 = last_acc[0];
        lim = 0;
        while (src_q[0].size() != 0 && lim < 20) begin
            drive_step();
            lim++;
        end
        to_neg(n0 + 2 + 3 * DIV + 4);
        chk("rstmid_level_before", int'(lvl_s[0]), 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rr = cyc;
        to_neg(rr);
        chk("rstmid_tx", int'(tx_s[0]), 1);
        chk("rstmid_level", int'(lvl_s[0]), 0);
        chk("rstmid_busy", int'(busy_s[0]), 0);
        lows = 0;
        for (int k = 1; k <= 400; k++) begin
            to_neg(rr + k);
            if (tx_s[0] == 1'b0) lows++;
        end
        chk("rstmid_no_frames", lows, 0);

        // push and pop on the same edge with level 2
        for (int i = 0; i < 3; i++) src_q[0].push_back(8'(8'h5A + i));
        drive_step();
        drive_step();
        n0 = last_acc[0];
        lim = 0;
        while ((src_q[0].size() != 0 || vld[0]) && lim < 20) begin
            drive_step();
            lim++;
        end
        rr = n0 + 1 + 10 * DIV;
        to_neg(rr - 2);
        src_q[0].push_back(8'h96);
        drive_step();
        to_neg(rr - 1);
        chk("coinc_level_before", int'(lvl_s[0]), 2);
        drive_step();
        chk("coinc_accept_edge", last_acc[0], rr);
        to_neg(rr);
        chk("coinc_level_after", int'(lvl_s[0]), 2);
        run_idle("coinc");

        // randomized traffic on all three instances
        gap_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < ND; k++) begin
                w = 8'($urandom_range(0, 255));
                src_q[k].push_back(w);
            end
        end
        run_idle("rand");
        for (int k = 0; k < ND; k++) chk($sformatf("rand_level_end%0d", k), int'(lvl_s[k]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
